// File: rtl/voq_match_if.sv
// Scheduler-side bundle between the VOQ occupancy tracker (master) and the
// round-robin matching scheduler (slave).
interface voq_match_if #(
  parameter int N_PORTS = 4
);
  localparam int PORT_W = $clog2(N_PORTS);

  // Handshake: start is a request that is accepted only on a rising edge where
  // busy is low; it is never queued. done pulses for one cycle when match_*
  // and egress_taken are final, and they hold until the next accepted start.
  logic                         start;
  logic [N_PORTS*N_PORTS-1:0]   voq_empty;
  logic                         busy;
  logic                         done;
  logic [N_PORTS-1:0]           match_valid;
  logic [N_PORTS*PORT_W-1:0]    match_egress;
  logic [N_PORTS-1:0]           egress_taken;

  modport master (
    output start, voq_empty,
    input  busy, done, match_valid, match_egress, egress_taken
  );

  modport slave (
    input  start, voq_empty,
    output busy, done, match_valid, match_egress, egress_taken
  );
endinterface

// File: rtl/voq_match_scheduler.sv
// Multi-cycle round-robin crossbar scheduler: visits one ingress per cycle and
// grants it the first free, non-empty egress from its own rotating pointer.
module voq_match_scheduler #(
  parameter int N_PORTS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  voq_match_if.slave                    bus,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(N_PORTS)-1:0]    dbg_iptr,
  output logic [N_PORTS*$clog2(N_PORTS)-1:0] dbg_vptr
);
  localparam int PORT_W = $clog2(N_PORTS);
  localparam logic [PORT_W-1:0] ONE    = PORT_W'(1);
  localparam logic [PORT_W-1:0] K_LAST = PORT_W'(N_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [N_PORTS-1:0][N_PORTS-1:0] snap;
  logic [N_PORTS-1:0][PORT_W-1:0]  vptr;
  logic [N_PORTS-1:0][PORT_W-1:0]  match_egress_q;
  logic [N_PORTS-1:0]              match_valid_q;
  logic [N_PORTS-1:0]              taken_q;
  logic [PORT_W-1:0]               iptr;
  logic [PORT_W-1:0]               k;

  logic [PORT_W-1:0] cur;
  logic [PORT_W-1:0] cand;
  logic              hit;
  logic [PORT_W-1:0] hit_j;
  logic              busy_c;
  logic              done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Search runs from the farthest candidate down so the nearest one (m=0) wins.
  always_comb begin
    next_state = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    hit        = 1'b0;
    hit_j      = '0;
    cand       = '0;
    cur        = iptr + k;
    for (int m = N_PORTS - 1; m >= 0; m--) begin
      cand = vptr[cur] + PORT_W'(m);
      if (!snap[cur][cand] && !taken_q[cand]) begin
        hit   = 1'b1;
        hit_j = cand;
      end
    end
    case (state)
      IDLE: begin
        if (bus.start) next_state = SCAN;
      end
      SCAN: begin
        busy_c = 1'b1;
        if (k == K_LAST) next_state = DONE;
      end
      DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap           <= '0;
      vptr           <= '0;
      match_egress_q <= '0;
      match_valid_q  <= '0;
      taken_q        <= '0;
      iptr           <= '0;
      k              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            snap           <= bus.voq_empty;
            match_valid_q  <= '0;
            match_egress_q <= '0;
            taken_q        <= '0;
            k              <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            match_valid_q[cur]  <= 1'b1;
            match_egress_q[cur] <= hit_j;
            taken_q[hit_j]      <= 1'b1;
            vptr[cur]           <= hit_j + ONE;
          end
          k <= k + ONE;
        end
        DONE: begin
          iptr <= iptr + ONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
  assign bus.match_valid  = match_valid_q;
  assign bus.match_egress = match_egress_q;
  assign bus.egress_taken = taken_q;

  assign dbg_state = state;
  assign dbg_iptr  = iptr;
  assign dbg_vptr  = vptr;
endmodule
